// File: rtl/plaintext_result_memory_pkg.sv
// rtl/plaintext_result_memory_pkg.sv - shared sizes, FSM encoding and helpers for the result buffer
//
// Purpose: the geometry shared with the cyphertext/key ROM, the capture FSM
// state encoding, and the run-length clamp helper.
// Ports: none (package).
package plaintext_result_memory_pkg;

  localparam int TEXT_WIDTH  = 128;
  localparam int ADDR_WIDTH  = 4;
  localparam int MEMORY_SIZE = 16;

  localparam logic [ADDR_WIDTH:0] MEMORY_SIZE_CNT = MEMORY_SIZE[ADDR_WIDTH:0];

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } state_e;

  // A run never asks for more blocks than the buffer can hold.
  function automatic logic [ADDR_WIDTH:0] clamp_count(input logic [ADDR_WIDTH:0] count);
    return (count > MEMORY_SIZE_CNT) ? MEMORY_SIZE_CNT : count;
  endfunction

endpackage

// File: rtl/plaintext_result_memory_result_ram.sv
// rtl/plaintext_result_memory_result_ram.sv - 1W1R synchronous RAM, read-before-write
//
// Purpose: storage behind the result buffer. One write port, one registered
// read port. A read and a write to the same address on one edge return the
// old contents. Reads beyond DEPTH return zero. Contents are not reset.
// Ports:
//   clk        in   clock, posedge
//   rst_n      in   synchronous active-low reset (read register only)
//   wr_en      in   write strobe
//   wr_addr    in   write address
//   wr_data    in   write data
//   rd_addr    in   read address
//   rd_data_q  out  registered read data, 1-cycle latency
module plaintext_result_memory_result_ram #(
  parameter int DATA_WIDTH = 128,
  parameter int ADDR_WIDTH = 4,
  parameter int DEPTH      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data_q
);

  logic [DATA_WIDTH-1:0] mem [0:DEPTH-1];
  logic                  rd_in_range;

  // Widened before comparing so the test stays meaningful for any DEPTH.
  assign rd_in_range = {{(32-ADDR_WIDTH){1'b0}}, rd_addr} < DEPTH;

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Non-blocking update of mem means this read sees the pre-write value.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rd_data_q <= '0;
    end else if (rd_in_range) begin
      rd_data_q <= mem[rd_addr];
    end else begin
      rd_data_q <= '0;
    end
  end

endmodule

// File: rtl/plaintext_result_memory.sv
// rtl/plaintext_result_memory.sv - result buffer at the output of the AES-128 decrypt datapath
//
// Purpose: captures decrypted plaintext blocks over a valid/ready handshake
// into sequential addresses and offers a registered read-back port.
// Optional feature macro: PLAINTEXT_CHECK_EN (compare each accepted block
// against an expect memory and count mismatches).
// Ports:
//   clk_i              in   clock, posedge
//   rst_ni             in   synchronous active-low reset
//   start_i            in   begin a capture run, samples count_i
//   clear_i            in   return to IDLE, clear counters and flags
//   count_i            in   blocks expected this run
//   plaintext_valid_i  in   plaintext_i holds a block
//   plaintext_i        in   decrypted block
//   plaintext_ready_o  out  buffer accepts a block this cycle (WRITE)
//   rd_addr_i          in   read-back address
//   rd_data_q          out  registered read-back data
//   wr_cnt_q           out  blocks written this run
//   busy_o             out  state is WRITE
//   done_o             out  state is DONE
//   overflow_q         out  sticky: block offered while in DONE
//   mismatch_cnt_q     out  (PLAINTEXT_CHECK_EN) blocks differing from expect memory
//   pass_o             out  (PLAINTEXT_CHECK_EN) done with zero mismatches
module plaintext_result_memory
  import plaintext_result_memory_pkg::*;
(
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  start_i,
  input  logic                  clear_i,
  input  logic [ADDR_WIDTH:0]   count_i,
  input  logic                  plaintext_valid_i,
  input  logic [TEXT_WIDTH-1:0] plaintext_i,
  output logic                  plaintext_ready_o,
  input  logic [ADDR_WIDTH-1:0] rd_addr_i,
  output logic [TEXT_WIDTH-1:0] rd_data_q,
  output logic [ADDR_WIDTH:0]   wr_cnt_q,
  output logic                  busy_o,
  output logic                  done_o,
`ifdef PLAINTEXT_CHECK_EN
  output logic [ADDR_WIDTH:0]   mismatch_cnt_q,
  output logic                  pass_o,
`endif
  output logic                  overflow_q
);

  state_e              state_q, state_d;
  logic [ADDR_WIDTH:0] target_q, target_d;
  logic [ADDR_WIDTH:0] wr_cnt_d;
  logic                overflow_d;
  logic                wr_en;

  assign plaintext_ready_o = (state_q == WRITE);
  assign busy_o            = (state_q == WRITE);
  assign done_o            = (state_q == DONE);

  // clear_i beats everything, including a block offered in the same cycle.
  always_comb begin
    state_d    = state_q;
    target_d   = target_q;
    wr_cnt_d   = wr_cnt_q;
    overflow_d = overflow_q;
    wr_en      = 1'b0;
    if (clear_i) begin
      state_d    = IDLE;
      wr_cnt_d   = '0;
      overflow_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (start_i) begin
            target_d = clamp_count(count_i);
            wr_cnt_d = '0;
            state_d  = (count_i == '0) ? DONE : WRITE;
          end
        end
        WRITE: begin
          if (plaintext_valid_i) begin
            wr_en    = 1'b1;
            wr_cnt_d = wr_cnt_q + 1'b1;
            if (wr_cnt_d == target_q) begin
              state_d = DONE;
            end
          end
        end
        DONE: begin
          if (plaintext_valid_i) begin
            overflow_d = 1'b1;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q    <= IDLE;
      target_q   <= '0;
      wr_cnt_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      target_q   <= target_d;
      wr_cnt_q   <= wr_cnt_d;
      overflow_q <= overflow_d;
    end
  end

`ifdef PLAINTEXT_CHECK_EN
  logic [TEXT_WIDTH-1:0] expect_memory [0:MEMORY_SIZE-1];

  always_ff @(posedge clk_i) begin
    if (!rst_ni || clear_i) begin
      mismatch_cnt_q <= '0;
    end else if (wr_en && (plaintext_i != expect_memory[wr_cnt_q[ADDR_WIDTH-1:0]])) begin
      mismatch_cnt_q <= mismatch_cnt_q + 1'b1;
    end
  end

  assign pass_o = done_o & (mismatch_cnt_q == '0);
`endif

  plaintext_result_memory_result_ram #(
    .DATA_WIDTH (TEXT_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH),
    .DEPTH      (MEMORY_SIZE)
  ) u_result_ram (
    .clk       (clk_i),
    .rst_n     (rst_ni),
    .wr_en     (wr_en),
    .wr_addr   (wr_cnt_q[ADDR_WIDTH-1:0]),
    .wr_data   (plaintext_i),
    .rd_addr   (rd_addr_i),
    .rd_data_q (rd_data_q)
  );

endmodule

// File: tb/tb_plaintext_result_memory.sv
// tb/tb_plaintext_result_memory.sv - directed self-checking bench for plaintext_result_memory
module tb_plaintext_result_memory;

  localparam int TW = 128;
  localparam int AW = 4;

  logic          clk = 1'b0;
  logic          rst_ni;
  logic          start_i;
  logic          clear_i;
  logic [AW:0]   count_i;
  logic          plaintext_valid_i;
  logic [TW-1:0] plaintext_i;
  logic          plaintext_ready_o;
  logic [AW-1:0] rd_addr_i;
  logic [TW-1:0] rd_data_q;
  logic [AW:0]   wr_cnt_q;
  logic          busy_o;
  logic          done_o;
  logic          overflow_q;
`ifdef PLAINTEXT_CHECK_EN
  logic [AW:0]   mismatch_cnt_q;
  logic          pass_o;
`endif

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  plaintext_result_memory dut (
    .clk_i             (clk),
    .rst_ni            (rst_ni),
    .start_i           (start_i),
    .clear_i           (clear_i),
    .count_i           (count_i),
    .plaintext_valid_i (plaintext_valid_i),
    .plaintext_i       (plaintext_i),
    .plaintext_ready_o (plaintext_ready_o),
    .rd_addr_i         (rd_addr_i),
    .rd_data_q         (rd_data_q),
    .wr_cnt_q          (wr_cnt_q),
    .busy_o            (busy_o),
    .done_o            (done_o),
`ifdef PLAINTEXT_CHECK_EN
    .mismatch_cnt_q    (mismatch_cnt_q),
    .pass_o            (pass_o),
`endif
    .overflow_q        (overflow_q)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_clear();
    clear_i = 1'b1;
    tick();
    clear_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    tick();
    tick();
    n_cmp++; if (plaintext_ready_o !== 1'b0) begin n_err++; $display("FAIL reset_ready got %b want 0", plaintext_ready_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL reset_busy got %b want 0", busy_o); end
    n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL reset_done got %b want 0", done_o); end
    n_cmp++; if (wr_cnt_q !== 5'd0) begin n_err++; $display("FAIL reset_wr_cnt got %0d want 0", wr_cnt_q); end
    n_cmp++; if (overflow_q !== 1'b0) begin n_err++; $display("FAIL reset_overflow got %b want 0", overflow_q); end
    n_cmp++; if (rd_data_q !== '0) begin n_err++; $display("FAIL reset_rd_data got %h want 0", rd_data_q); end
    rst_ni = 1'b1;
    tick();
  endtask

  task automatic test_back_to_back();
    start_i = 1'b1; count_i = 5'd3;
    tick();
    start_i = 1'b0;
    n_cmp++; if (busy_o !== 1'b1) begin n_err++; $display("FAIL b2b_busy got %b want 1", busy_o); end
    for (int k = 1; k <= 3; k++) begin
      plaintext_valid_i = 1'b1;
      plaintext_i = TW'(k);
      n_cmp++; if (plaintext_ready_o !== 1'b1) begin n_err++; $display("FAIL b2b_ready[%0d] got %b want 1", k, plaintext_ready_o); end
      tick();
      n_cmp++; if (wr_cnt_q !== 5'(k)) begin n_err++; $display("FAIL b2b_wr_cnt[%0d] got %0d want %0d", k, wr_cnt_q, k); end
    end
    n_cmp++; if (done_o !== 1'b1) begin n_err++; $display("FAIL b2b_done got %b want 1", done_o); end
    n_cmp++; if (plaintext_ready_o !== 1'b0) begin n_err++; $display("FAIL b2b_ready_done got %b want 0", plaintext_ready_o); end
    plaintext_valid_i = 1'b0;
    for (int a = 0; a < 3; a++) begin
      rd_addr_i = AW'(a);
      tick();
      n_cmp++; if (rd_data_q !== TW'(a + 1)) begin n_err++; $display("FAIL b2b_read[%0d] got %h want %h", a, rd_data_q, TW'(a + 1)); end
    end
    n_cmp++; if (overflow_q !== 1'b0) begin n_err++; $display("FAIL b2b_overflow got %b want 0", overflow_q); end
    do_clear();
    n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL b2b_clear_done got %b want 0", done_o); end
  endtask

  task automatic test_valid_toggle();
    start_i = 1'b1; count_i = 5'd4;
    tick();
    start_i = 1'b0;
    for (int c = 0; c < 8; c++) begin
      plaintext_valid_i = (c % 2 == 0);
      plaintext_i = (c % 2 == 0) ? TW'(8'hA0 + c / 2) : TW'(8'hEE);
      tick();
      n_cmp++; if (wr_cnt_q !== 5'(c / 2 + 1)) begin n_err++; $display("FAIL toggle_wr_cnt[%0d] got %0d want %0d", c, wr_cnt_q, c / 2 + 1); end
      n_cmp++; if (done_o !== (c >= 6)) begin n_err++; $display("FAIL toggle_done[%0d] got %b want %b", c, done_o, c >= 6); end
    end
    plaintext_valid_i = 1'b0;
    for (int a = 0; a < 4; a++) begin
      rd_addr_i = AW'(a);
      tick();
      n_cmp++; if (rd_data_q !== TW'(8'hA0 + a)) begin n_err++; $display("FAIL toggle_read[%0d] got %h want %h", a, rd_data_q, TW'(8'hA0 + a)); end
    end
    do_clear();
  endtask

  task automatic test_clamp_overflow();
    start_i = 1'b1; count_i = 5'd20;
    tick();
    start_i = 1'b0;
    for (int i = 0; i < 16; i++) begin
      plaintext_valid_i = 1'b1;
      plaintext_i = TW'(12'h100 + i);
      tick();
    end
    n_cmp++; if (wr_cnt_q !== 5'd16) begin n_err++; $display("FAIL clamp_wr_cnt got %0d want 16", wr_cnt_q); end
    n_cmp++; if (done_o !== 1'b1) begin n_err++; $display("FAIL clamp_done got %b want 1", done_o); end
    n_cmp++; if (overflow_q !== 1'b0) begin n_err++; $display("FAIL clamp_overflow_early got %b want 0", overflow_q); end
    tick();
    n_cmp++; if (overflow_q !== 1'b1) begin n_err++; $display("FAIL clamp_overflow got %b want 1", overflow_q); end
    n_cmp++; if (wr_cnt_q !== 5'd16) begin n_err++; $display("FAIL clamp_wr_cnt_hold got %0d want 16", wr_cnt_q); end
    plaintext_valid_i = 1'b0;
    tick();
    n_cmp++; if (overflow_q !== 1'b1) begin n_err++; $display("FAIL clamp_overflow_sticky got %b want 1", overflow_q); end
    do_clear();
    n_cmp++; if (done_o !== 1'b0) begin n_err++; $display("FAIL clamp_clear_done got %b want 0", done_o); end
    n_cmp++; if (overflow_q !== 1'b0) begin n_err++; $display("FAIL clamp_clear_overflow got %b want 0", overflow_q); end
    n_cmp++; if (wr_cnt_q !== 5'd0) begin n_err++; $display("FAIL clamp_clear_wr_cnt got %0d want 0", wr_cnt_q); end
    rd_addr_i = 4'd15;
    tick();
    n_cmp++; if (rd_data_q !== TW'(12'h10F)) begin n_err++; $display("FAIL clamp_read15 got %h want 10f", rd_data_q); end
  endtask

  task automatic test_read_during_write();
    start_i = 1'b1; count_i = 5'd3;
    tick();
    start_i = 1'b0;
    plaintext_valid_i = 1'b1;
    plaintext_i = TW'(12'h301);
    tick();
    plaintext_i = TW'(12'h302);
    tick();
    plaintext_i = TW'(12'h303);
    rd_addr_i = 4'd2;
    tick();
    n_cmp++; if (rd_data_q !== TW'(12'h102)) begin n_err++; $display("FAIL rbw_old got %h want 102", rd_data_q); end
    n_cmp++; if (done_o !== 1'b1) begin n_err++; $display("FAIL rbw_done got %b want 1", done_o); end
    plaintext_valid_i = 1'b0;
    tick();
    n_cmp++; if (rd_data_q !== TW'(12'h303)) begin n_err++; $display("FAIL rbw_new got %h want 303", rd_data_q); end
    do_clear();
  endtask

  task automatic test_reset_midrun();
    start_i = 1'b1; count_i = 5'd5;
    tick();
    start_i = 1'b0;
    plaintext_valid_i = 1'b1;
    plaintext_i = TW'(12'h501);
    tick();
    plaintext_i = TW'(12'h502);
    tick();
    rst_ni = 1'b0;
    tick();
    n_cmp++; if (plaintext_ready_o !== 1'b0) begin n_err++; $display("FAIL midrst_ready got %b want 0", plaintext_ready_o); end
    n_cmp++; if (busy_o !== 1'b0) begin n_err++; $display("FAIL midrst_busy got %b want 0", busy_o); end
    n_cmp++; if (wr_cnt_q !== 5'd0) begin n_err++; $display("FAIL midrst_wr_cnt got %0d want 0", wr_cnt_q); end
    rst_ni = 1'b1;
    start_i = 1'b1; count_i = 5'd0;
    plaintext_i = TW'(16'hDEAD);
    tick();
    start_i = 1'b0;
    plaintext_valid_i = 1'b0;
    n_cmp++; if (done_o !== 1'b1) begin n_err++; $display("FAIL zero_done got %b want 1", done_o); end
    n_cmp++; if (wr_cnt_q !== 5'd0) begin n_err++; $display("FAIL zero_wr_cnt got %0d want 0", wr_cnt_q); end
    n_cmp++; if (overflow_q !== 1'b0) begin n_err++; $display("FAIL zero_overflow got %b want 0", overflow_q); end
    rd_addr_i = 4'd0;
    tick();
    n_cmp++; if (rd_data_q !== TW'(12'h501)) begin n_err++; $display("FAIL zero_nowrite got %h want 501", rd_data_q); end
    do_clear();
  endtask

  task automatic test_start_clear_priority();
    start_i = 1'b1; clear_i = 1'b1; count_i = 5'd2;
    tick();
    start_i = 1'b0; clear_i = 1'b0;
    n_cmp++; if (busy_o !== 1'b0 || done_o !== 1'b0) begin n_err++; $display("FAIL clear_wins got busy=%b done=%b want 0 0", busy_o, done_o); end
    start_i = 1'b1;
    tick();
    start_i = 1'b0;
    plaintext_valid_i = 1'b1;
    plaintext_i = TW'(12'h601);
    tick();
    start_i = 1'b1; count_i = 5'd4;
    plaintext_i = TW'(12'h602);
    tick();
    start_i = 1'b0;
    plaintext_valid_i = 1'b0;
    n_cmp++; if (done_o !== 1'b1) begin n_err++; $display("FAIL start_ignored_done got %b want 1", done_o); end
    n_cmp++; if (wr_cnt_q !== 5'd2) begin n_err++; $display("FAIL start_ignored_wr_cnt got %0d want 2", wr_cnt_q); end
    do_clear();
  endtask

`ifdef PLAINTEXT_CHECK_EN
  task automatic test_check();
    dut.expect_memory[0] = TW'(12'hA01);
    dut.expect_memory[1] = TW'(12'hB02);
    dut.expect_memory[2] = TW'(12'hC03);
    start_i = 1'b1; count_i = 5'd3;
    tick();
    start_i = 1'b0;
    plaintext_valid_i = 1'b1;
    plaintext_i = TW'(12'hA01);
    tick();
    plaintext_i = TW'(12'hBAD);
    tick();
    plaintext_i = TW'(12'hC03);
    tick();
    plaintext_valid_i = 1'b0;
    n_cmp++; if (mismatch_cnt_q !== 5'd1) begin n_err++; $display("FAIL check_mismatch got %0d want 1", mismatch_cnt_q); end
    n_cmp++; if (pass_o !== 1'b0) begin n_err++; $display("FAIL check_pass got %b want 0", pass_o); end
    do_clear();
    n_cmp++; if (mismatch_cnt_q !== 5'd0) begin n_err++; $display("FAIL check_clear got %0d want 0", mismatch_cnt_q); end
  endtask
`endif

  initial begin
    rst_ni = 1'b0;
    start_i = 1'b0;
    clear_i = 1'b0;
    count_i = '0;
    plaintext_valid_i = 1'b0;
    plaintext_i = '0;
    rd_addr_i = '0;
    test_reset();
    test_back_to_back();
    test_valid_toggle();
    test_clamp_overflow();
    test_read_during_write();
    test_reset_midrun();
    test_start_clear_priority();
`ifdef PLAINTEXT_CHECK_EN
    test_check();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
